// File: rtl/tree_pkg.sv
// Shared definitions for the tree hierarchy fan-in/fan-out blocks.
package tree_pkg;

  // Default number of children under each hierarchy node.
  localparam int TREE_FANOUT = 10;

  // Default field widths for the uplink record at the standard fanout.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_SRC_W  = 4;

  // Width of a child-index tag. The result is never narrower than one bit.
  function automatic int src_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // One uplink record: the payload plus the index of the child that sent it.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_SRC_W-1:0]  src;
  } uplink_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts just after last_grant
// and wraps modulo N. The caller owns the last_grant register.
module rr_arbiter
  import tree_pkg::*;
#(
  parameter  int N = TREE_FANOUT,
  localparam int W = src_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         any_req,
  output logic [W-1:0] gnt_idx
);

  int           sum;
  logic [W-1:0] cand;

  // Scan children in rotating priority order and pick the first requester.
  always_comb begin
    any_req = 1'b0;
    gnt_idx = '0;
    sum     = 0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      sum = int'(last_grant) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      cand = W'(sum);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/tree_uplink_collector.sv
// Fan-in collector for one hierarchy node. It arbitrates round-robin across
// the child record ports and forwards the winner through a single registered
// valid/ready uplink stage. It also counts every record accepted from a child.
module tree_uplink_collector
  import tree_pkg::*;
#(
  parameter  int NUM_CHILDREN = TREE_FANOUT,
  parameter  int DATA_W       = 16,
  parameter  int CNT_W        = 32,
  localparam int SRC_W        = src_w(NUM_CHILDREN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                       up_valid,
  output logic [DATA_W-1:0]          up_data,
  output logic [SRC_W-1:0]           up_src,
  input  logic                       up_ready,
  output logic [CNT_W-1:0]           xfer_count
);

  logic              up_valid_q,   up_valid_d;
  logic [DATA_W-1:0] up_data_q,    up_data_d;
  logic [SRC_W-1:0]  up_src_q,     up_src_d;
  logic [SRC_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

  logic              load_en;
  logic              any_req;
  logic [SRC_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;

  rr_arbiter #(
    .N (NUM_CHILDREN)
  ) u_arb (
    .req        (child_valid),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .gnt_idx    (gnt_idx)
  );

  // The output stage accepts a new record when it is empty or is being drained
  // this cycle. Only the granted child's payload is routed to the register.
  always_comb begin
    load_en      = !up_valid_q || up_ready;
    gnt_data     = child_data[int'(gnt_idx)*DATA_W +: DATA_W];
    child_ready  = '0;
    up_valid_d   = up_valid_q;
    up_data_d    = up_data_q;
    up_src_d     = up_src_q;
    last_grant_d = last_grant_q;
    xfer_count_d = xfer_count_q;
    if (load_en) begin
      if (any_req) begin
        child_ready[gnt_idx] = 1'b1;
        up_valid_d           = 1'b1;
        up_data_d            = gnt_data;
        up_src_d             = gnt_idx;
        last_grant_d         = gnt_idx;
        xfer_count_d         = xfer_count_q + 1'b1;
      end else begin
        up_valid_d = 1'b0;
      end
    end
  end

  // Uplink register, round-robin pointer and transfer counter. The pointer
  // resets to the last child so that child 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_valid_q   <= 1'b0;
      up_data_q    <= '0;
      up_src_q     <= '0;
      last_grant_q <= SRC_W'(NUM_CHILDREN - 1);
      xfer_count_q <= '0;
    end else begin
      up_valid_q   <= up_valid_d;
      up_data_q    <= up_data_d;
      up_src_q     <= up_src_d;
      last_grant_q <= last_grant_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign up_valid   = up_valid_q;
  assign up_data    = up_data_q;
  assign up_src     = up_src_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_tree_uplink_collector.sv
// Directed bench for tree_uplink_collector. A second instance with a 4-bit
// counter shares all inputs so that counter wrap-around can be observed.
module tb_tree_uplink_collector;
  import tree_pkg::*;

  localparam int N  = 10;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]    child_valid;
  logic [N*DW-1:0] child_data;
  logic [N-1:0]    child_ready;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic [3:0]    up_src;
  logic          up_ready;
  logic [31:0]   xfer_count;

  logic [N-1:0]  sChildReady;
  logic          sUpValid;
  logic [DW-1:0] sUpData;
  logic [3:0]    sUpSrc;
  logic [3:0]    sXferCount;

  logic [DW-1:0] childWord [N];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  tree_uplink_collector #(
    .NUM_CHILDREN (N),
    .DATA_W       (DW),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_src      (up_src),
    .up_ready    (up_ready),
    .xfer_count  (xfer_count)
  );

  tree_uplink_collector #(
    .NUM_CHILDREN (N),
    .DATA_W       (DW),
    .CNT_W        (4)
  ) dutSmall (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (sChildReady),
    .up_valid    (sUpValid),
    .up_data     (sUpData),
    .up_src      (sUpSrc),
    .up_ready    (up_ready),
    .xfer_count  (sXferCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack the per-child payload words into the flat data bus.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      child_data[i*DW +: DW] = childWord[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic ready);
    child_valid = valid;
    up_ready    = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    int expSrc;
    rst_n       = 1'b0;
    child_valid = '0;
    up_ready    = 1'b0;
    for (int i = 0; i < N; i++) childWord[i] = 16'h1000 + 16'(i);
    childWord[0] = 16'h00A0;
    childWord[2] = 16'h2222;
    childWord[5] = 16'h05A5;

    tick();
    tick();
    checkOutput("reset_up_valid", 32'(up_valid), 32'h0);
    checkOutput("reset_up_data", 32'(up_data), 32'h0);
    checkOutput("reset_up_src", 32'(up_src), 32'h0);
    checkOutput("reset_count", xfer_count, 32'h0);
    checkOutput("reset_count_small", 32'(sXferCount), 32'h0);

    // Load one record from child 2 and hold it with backpressure.
    rst_n = 1'b1;
    applyStimulus(10'b0000000100, 1'b0);
    checkOutput("first_ready", 32'(child_ready), 32'h004);
    tick();
    checkOutput("first_valid", 32'(up_valid), 32'h1);
    checkOutput("first_src", 32'(up_src), 32'h2);
    checkOutput("first_data", 32'(up_data), 32'h2222);
    checkOutput("first_count", xfer_count, 32'h1);
    checkOutput("held_ready", 32'(child_ready), 32'h000);

    // Reset mid-stream clears the pending record at once, with no clock edge.
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(up_valid), 32'h0);
    checkOutput("midreset_count", xfer_count, 32'h0);
    checkOutput("midreset_src", 32'(up_src), 32'h0);

    // After release, child 0 beats child 5.
    applyStimulus(10'b0000100001, 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("prio_ready", 32'(child_ready), 32'h001);
    tick();
    checkOutput("prio_valid", 32'(up_valid), 32'h1);
    checkOutput("prio_src", 32'(up_src), 32'h0);
    checkOutput("prio_data", 32'(up_data), 32'h00A0);
    checkOutput("prio_count", xfer_count, 32'h1);
    applyStimulus(10'b0000100000, 1'b1);
    checkOutput("second_ready", 32'(child_ready), 32'h020);
    tick();
    checkOutput("second_src", 32'(up_src), 32'h5);
    checkOutput("second_data", 32'(up_data), 32'h05A5);
    checkOutput("second_count", xfer_count, 32'h2);

    // Drain with no new requests: valid drops and the payload holds.
    applyStimulus(10'b0000000000, 1'b1);
    checkOutput("drain_ready", 32'(child_ready), 32'h000);
    tick();
    checkOutput("drain_valid", 32'(up_valid), 32'h0);
    checkOutput("drain_data", 32'(up_data), 32'h05A5);
    checkOutput("drain_src", 32'(up_src), 32'h5);
    checkOutput("drain_count", xfer_count, 32'h2);

    // Full rotation: every child is valid and the uplink is always ready.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) childWord[i] = 16'h1000 + 16'(i);
    applyStimulus('1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      checkOutput("rot_ready", 32'(child_ready), 32'(1 << (k % 10)));
      tick();
      checkOutput("rot_valid", 32'(up_valid), 32'h1);
      checkOutput("rot_src", 32'(up_src), 32'(k % 10));
      checkOutput("rot_data", 32'(up_data), 32'h1000 + 32'(k % 10));
      checkOutput("rot_count", xfer_count, 32'(k + 1));
      checkOutput("small_count_wrap", 32'(sXferCount), 32'((k + 1) % 16));
    end

    // Backpressure: the held record is stable and no child is accepted.
    applyStimulus('1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_ready", 32'(child_ready), 32'h000);
      checkOutput("bp_valid", 32'(up_valid), 32'h1);
      checkOutput("bp_data", 32'(up_data), 32'h1009);
      checkOutput("bp_src", 32'(up_src), 32'h9);
      checkOutput("bp_count", xfer_count, 32'd20);
      tick();
    end
    applyStimulus('1, 1'b1);
    checkOutput("bp_release_ready", 32'(child_ready), 32'h001);
    tick();
    checkOutput("bp_release_src", 32'(up_src), 32'h0);
    checkOutput("bp_release_data", 32'(up_data), 32'h1000);
    checkOutput("bp_release_count", xfer_count, 32'd21);

    // Sparse requests: move the pointer to 9, then alternate 3 and 9.
    applyStimulus(10'b1000000000, 1'b1);
    checkOutput("sparse_pre_ready", 32'(child_ready), 32'h200);
    tick();
    checkOutput("sparse_pre_src", 32'(up_src), 32'h9);
    checkOutput("sparse_pre_count", xfer_count, 32'd22);
    applyStimulus(10'b1000001000, 1'b1);
    for (int j = 0; j < 4; j++) begin
      expSrc = (j % 2 == 1) ? 9 : 3;
      checkOutput("sparse_ready", 32'(child_ready), 32'(1 << expSrc));
      tick();
      checkOutput("sparse_src", 32'(up_src), 32'(expSrc));
      checkOutput("sparse_data", 32'(up_data), 32'h1000 + 32'(expSrc));
      checkOutput("sparse_count", xfer_count, 32'(23 + j));
    end
    applyStimulus(10'b1000000000, 1'b1);
    checkOutput("regrant_ready", 32'(child_ready), 32'h200);
    tick();
    checkOutput("regrant_src", 32'(up_src), 32'h9);
    checkOutput("regrant_valid", 32'(up_valid), 32'h1);
    checkOutput("regrant_count", xfer_count, 32'd27);
    checkOutput("regrant_count_small", 32'(sXferCount), 32'd11);

    // Final drain.
    applyStimulus(10'b0000000000, 1'b1);
    tick();
    checkOutput("final_valid", 32'(up_valid), 32'h0);
    checkOutput("final_data", 32'(up_data), 32'h1009);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tree_uplink_collector.md
Name: tree_uplink_collector

Overview:
- Fan-in counterpart to the generated root/child fan-out hierarchy: gathers records from NUM_CHILDREN child instances and forwards them upward on one valid/ready uplink.
- Round-robin arbitration across children, one registered output stage, and a running transfer counter.
- Instantiated once per hierarchy node, between that node's children and its parent's collector.

Parameters:
- NUM_CHILDREN, 10, number of child request ports (2..16).
- DATA_W, 16, payload width per record.
- CNT_W, 32, width of the transfer counter.
- SRC_W, $clog2(NUM_CHILDREN), width of the source-index tag (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- child_valid  in  NUM_CHILDREN  per-child record-valid.
- child_data  in  NUM_CHILDREN*DATA_W  packed payloads; child i occupies bits [i*DATA_W +: DATA_W].
- child_ready  out  NUM_CHILDREN  per-child accept; at most one bit high per cycle.
- up_valid  out  1  uplink record valid (registered).
- up_data  out  DATA_W  uplink payload (registered).
- up_src  out  SRC_W  index of the child that produced up_data (registered).
- up_ready  in  1  parent accept.
- xfer_count  out  CNT_W  number of records accepted from children since reset.

Behaviour:
- Reset (async assert, sync release): up_valid=0, up_data=0, up_src=0, xfer_count=0, last_grant=NUM_CHILDREN-1, so child 0 has first priority.
- load_en = !up_valid || up_ready. The output register is free or is being drained this cycle.
- Arbitration is combinational. Search order is last_grant+1, last_grant+2, ..., wrapping modulo NUM_CHILDREN. The first child with child_valid=1 becomes gnt_idx.
- child_ready[gnt_idx] = load_en && any child_valid. All other child_ready bits are 0.
  - child_ready may depend on child_valid.
  - child_valid must not depend on child_ready (standard valid/ready rule).
- A transfer from child i occurs when child_valid[i] && child_ready[i]. On that rising edge:
  - up_data <= that child's payload.
  - up_src <= i.
  - up_valid <= 1.
  - last_grant <= i.
  - xfer_count increments.
- If load_en=1 and no child is valid: up_valid <= 0 (the drained record leaves). up_data, up_src and last_grant hold.
- If load_en=0 (up_valid=1, up_ready=0): up_valid, up_data and up_src hold stable, and all child_ready=0.
- Latency: a child record appears on the uplink 1 cycle after acceptance.
- Throughput: 1 record/cycle when up_ready is held high.
- Fairness: with all children continuously valid, grants rotate 0,1,...,N-1,0,... Each child waits at most N-1 grants.
- Simultaneous drain and load: when up_valid=1, up_ready=1 and a child is valid, the new record replaces the old with no bubble. up_valid stays 1.
- Wrap-around:
  - Round-robin pointer goes from N-1 to 0.
  - xfer_count wraps from 2^CNT_W-1 to 0, with no saturation or flag.
- Reset mid-operation: the pending uplink record is discarded (up_valid=0), the pointer returns to N-1, and the count clears. Children are unaffected: any child still valid re-presents its record and is granted after release.
- X-safety: child_data of non-granted children is never sampled.

Decomposition:
- Shared package tree_pkg:
  - Constant TREE_FANOUT = 10.
  - Function src_w(n), returning $clog2(n), minimum 1.
  - Typedef uplink_rec_t {data, src}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], last_grant.
  - Outputs: any_req, gnt_idx.
  - Purely combinational; the collector owns the last_grant register.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream while up_valid=1 -> up_valid=0, xfer_count=0 immediately. After release, child 0 (data 0x00A0) wins over child 5 (0x05A5) when both are valid: up_src=0, up_data=0x00A0 one cycle later.
- Full rotation: all 10 children valid, child i data=0x1000+i, up_ready=1 for 20 cycles -> up_src sequence 0..9,0..9, one record per cycle, xfer_count=20.
- Backpressure: up_ready=0 for 5 cycles with up_valid=1 -> up_data and up_src constant, child_ready=0 throughout, xfer_count unchanged. Release -> next grant goes to last_grant+1.
- Sparse/wrap: only children 3 and 9 valid, last_grant=9 -> grant order 3,9,3,9. With only child 9 valid after grant 9 -> child 9 is re-granted.
- Counter wrap: CNT_W=4, 17 transfers -> xfer_count reads 1.
- Drain with no new requests: up_valid=1, up_ready=1, no child valid -> up_valid=0 next cycle and up_data holds its previous value.
